// File: rtl/bfm_apb_pkg.sv
// ---------------------------------------------------------------------------
// bfm_apb_pkg
// Shared types and constants for the behavioural APB responder model.
//   state_t             : responder FSM states (IDLE / WAIT / READY)
//   DATA_W              : APB data width
//   ERR_REGION_DEFAULT  : default PADDR[31:28] value that selects the error region
//   ERR_RDATA_DEFAULT   : default PRDATA returned for reads in the error region
//   IDX_LSB             : lowest PADDR bit used as the word index
//   REGION_MSB/LSB      : PADDR bit range compared against the error region
// ---------------------------------------------------------------------------
package bfm_apb_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0]  ERR_REGION_DEFAULT = 4'hF;
    localparam logic [31:0] ERR_RDATA_DEFAULT  = 32'h0000_0000;

    localparam int IDX_LSB    = 2;
    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/bfm_apb_resp_mem.sv
// ---------------------------------------------------------------------------
// bfm_apb_resp_mem
// Backing word memory for the APB responder: 2^AW x DATA_W, synchronous
// write, asynchronous read. Contents start at zero and are not touched by
// any reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data (combinational)
// ---------------------------------------------------------------------------
module bfm_apb_resp_mem
    import bfm_apb_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    // Zero contents at time 0; deliberately outside any reset domain.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bfm_apb_responder.sv
// ---------------------------------------------------------------------------
// bfm_apb_responder
// Behavioural APB completer: memory-backed transfers, programmable wait
// states, an optional error address region, sticky protocol-violation flag
// and a completed-transfer counter. All outputs are registered.
//   PCLK, PRESET        : clock, synchronous active-high reset
//   PSEL .. PWDATA      : APB request from the requester
//   PRDATA, PREADY,
//   PSLVERR             : APB response
//   WAIT_CYCLES         : wait states for the transfer, taken at setup
//   ERR_ENABLE          : arms the error region, taken at setup
//   XFER_COUNT          : completed transfers (wraps)
//   PROTOCOL_ERR        : sticky requester protocol violation
// ---------------------------------------------------------------------------
module bfm_apb_responder
    import bfm_apb_pkg::*;
#(
    parameter int          MEM_AW     = 8,
    parameter logic [3:0]  ERR_REGION = ERR_REGION_DEFAULT,
    parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [3:0]  WAIT_CYCLES,
    input  logic        ERR_ENABLE,
    output logic [15:0] XFER_COUNT,
    output logic        PROTOCOL_ERR
);

    state_t state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [15:0] xfer_q, xfer_d;
    logic        proto_q, proto_d;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    logic        is_setup;
    logic        is_access;
    logic        setup_err;
    logic        mismatch;
    logic        cur_write;
    logic        cur_err;
    logic [31:0] resp_rdata;

    assign is_setup  = PSEL && !PENABLE;
    assign is_access = PSEL && PENABLE;
    assign setup_err = ERR_ENABLE && (PADDR[REGION_MSB:REGION_LSB] == ERR_REGION);
    assign mismatch  = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);

    // A zero-wait transfer responds at its setup edge, before anything is
    // latched, so the response is built from the live bus in IDLE and from
    // the latched request otherwise.
    assign mem_raddr  = (state_q == IDLE) ? PADDR[MEM_AW+IDX_LSB-1:IDX_LSB]
                                          : addr_q[MEM_AW+IDX_LSB-1:IDX_LSB];
    assign cur_write  = (state_q == IDLE) ? PWRITE : write_q;
    assign cur_err    = (state_q == IDLE) ? setup_err : err_q;
    assign resp_rdata = cur_write ? 32'h0 : (cur_err ? ERR_RDATA : mem_rdata);

    bfm_apb_resp_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk   (PCLK),
        .we    (mem_we),
        .waddr (addr_q[MEM_AW+IDX_LSB-1:IDX_LSB]),
        .wdata (wdata_q),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // State and datapath registers; reset overrides every other event.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            xfer_q    <= '0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            xfer_q    <= xfer_d;
            proto_q   <= proto_d;
        end
    end

    // Next-state logic. Any dropped PSEL/PENABLE during a transfer aborts
    // to IDLE; READY always returns to IDLE (completion or abort).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_setup) begin
                    state_d = (WAIT_CYCLES == 4'd0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!is_access) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = READY;
                end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the latched request, response outputs, counter and
    // protocol flag. Response outputs default to cleared.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        xfer_d    = xfer_q;
        proto_d   = proto_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_setup) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    err_d   = setup_err;
                    cnt_d   = WAIT_CYCLES;
                    if (WAIT_CYCLES == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = resp_rdata;
                    end
                end else if (is_access) begin
                    proto_d = 1'b1;
                end
            end
            WAIT: begin
                if (!is_access) begin
                    proto_d = 1'b1;
                end else begin
                    if (mismatch) begin
                        proto_d = 1'b1;
                    end
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = resp_rdata;
                    end
                end
            end
            READY: begin
                if (!is_access) begin
                    proto_d = 1'b1;
                end else begin
                    if (mismatch) begin
                        proto_d = 1'b1;
                    end
                    // Error-region writes never reach memory; a reset in the
                    // same cycle discards the write.
                    mem_we = write_q && !err_q && !PRESET;
                    xfer_d = xfer_q + 16'd1;
                end
            end
            default: begin
                proto_d = proto_q;
            end
        endcase
    end

    assign PRDATA       = prdata_q;
    assign PREADY       = pready_q;
    assign PSLVERR      = pslverr_q;
    assign XFER_COUNT   = xfer_q;
    assign PROTOCOL_ERR = proto_q;

endmodule

// File: tb/tb_bfm_apb_responder.sv
// ---------------------------------------------------------------------------
// tb_bfm_apb_responder
// Directed bench for bfm_apb_responder: a table of complete transfers with
// hand-computed responses, followed by hand-written abort, reset and
// idle-violation sequences.
// ---------------------------------------------------------------------------
module tb_bfm_apb_responder;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  WAIT_CYCLES;
    logic        ERR_ENABLE;
    logic [15:0] XFER_COUNT;
    logic        PROTOCOL_ERR;

    int tests_run;
    int tests_failed;

    bfm_apb_responder #(
        .MEM_AW     (8),
        .ERR_REGION (4'hF),
        .ERR_RDATA  (32'h0000_0000)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .WAIT_CYCLES  (WAIT_CYCLES),
        .ERR_ENABLE   (ERR_ENABLE),
        .XFER_COUNT   (XFER_COUNT),
        .PROTOCOL_ERR (PROTOCOL_ERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  waits;
        logic        err_en;
        logic        b2b;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
    } vec_t;

    localparam int NUM_VECS = 11;
    vec_t vecs [NUM_VECS];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Drives setup, then enters the first access cycle and returns there.
    task automatic start_transfer(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] waits);
        PSEL        = 1'b1;
        PENABLE     = 1'b0;
        PWRITE      = wr;
        PADDR       = addr;
        PWDATA      = wdata;
        WAIT_CYCLES = waits;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
    endtask

    // Runs one full transfer; returns just after the completion edge with
    // the bus released, so a following call is back-to-back.
    task automatic apply_stimulus(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] waits,
                                  input logic err_en,
                                  output logic [31:0] rdata, output logic slverr,
                                  output int wait_seen, output logic timed_out);
        ERR_ENABLE = err_en;
        start_transfer(wr, addr, wdata, waits);
        wait_seen = 0;
        timed_out = 1'b1;
        rdata     = '0;
        slverr    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (PREADY) begin
                rdata     = PRDATA;
                slverr    = PSLVERR;
                timed_out = 1'b0;
                break;
            end
            wait_seen++;
        end
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdata;
        logic        slverr;
        int          wait_seen;
        logic        timed_out;

        tests_run    = 0;
        tests_failed = 0;

        // wr, addr, wdata, waits, err_en, b2b, exp_rdata, exp_slverr
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 32'hA5A5_1234, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'd3, 1'b0, 1'b0, 32'hA5A5_1234, 1'b0};
        vecs[3]  = '{1'b1, 32'hF000_0010, 32'h1111_1111, 4'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 32'hF000_0010, 32'h0000_0000, 4'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'd0, 1'b1, 1'b0, 32'hA5A5_1234, 1'b0};
        vecs[6]  = '{1'b0, 32'hF000_0010, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 32'hA5A5_1234, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'hCAFE_0001, 4'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0FFF, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 32'h1234_5678, 1'b0};

        PRESET      = 1'b1;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        WAIT_CYCLES = '0;
        ERR_ENABLE  = 1'b0;
        idle_cycles(2);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_output("reset PREADY", {31'b0, PREADY}, 32'h0);
        check_output("reset PSLVERR", {31'b0, PSLVERR}, 32'h0);
        check_output("reset PRDATA", PRDATA, 32'h0);
        check_output("reset XFER_COUNT", {16'b0, XFER_COUNT}, 32'h0);
        check_output("reset PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h0);
        @(posedge PCLK);
        #1;

        // Table of complete transfers.
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                           vecs[i].err_en, rdata, slverr, wait_seen, timed_out);
            check_output($sformatf("v%0d timeout", i), {31'b0, timed_out}, 32'h0);
            check_output($sformatf("v%0d PRDATA", i), rdata, vecs[i].exp_rdata);
            check_output($sformatf("v%0d PSLVERR", i), {31'b0, slverr}, {31'b0, vecs[i].exp_slverr});
            check_output($sformatf("v%0d wait states", i), wait_seen, {28'b0, vecs[i].waits});
            check_output($sformatf("v%0d XFER_COUNT", i), {16'b0, XFER_COUNT}, i + 1);
            check_output($sformatf("v%0d PREADY after", i), {31'b0, PREADY}, 32'h0);
            if (!vecs[i].b2b) begin
                idle_cycles(1);
            end
        end
        check_output("table PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h0);

        // Abort: PSEL dropped in the 2nd access cycle of a 5-wait write.
        ERR_ENABLE = 1'b0;
        start_transfer(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'd5);
        @(posedge PCLK);
        #1;
        PSEL = 1'b0;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b0;
        check_output("abort PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h1);
        check_output("abort PREADY", {31'b0, PREADY}, 32'h0);
        check_output("abort XFER_COUNT", {16'b0, XFER_COUNT}, 32'd11);
        idle_cycles(3);
        check_output("abort sticky", {31'b0, PROTOCOL_ERR}, 32'h1);
        apply_stimulus(1'b0, 32'h0000_0020, 32'h0, 4'd0, 1'b0, rdata, slverr, wait_seen, timed_out);
        check_output("post-abort timeout", {31'b0, timed_out}, 32'h0);
        check_output("post-abort mem[8]", rdata, 32'h0);
        check_output("post-abort XFER_COUNT", {16'b0, XFER_COUNT}, 32'd12);
        check_output("post-abort sticky", {31'b0, PROTOCOL_ERR}, 32'h1);
        idle_cycles(1);

        // Reset during WAIT of a write.
        start_transfer(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 4'd4);
        @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check_output("rstwait PREADY", {31'b0, PREADY}, 32'h0);
        check_output("rstwait PSLVERR", {31'b0, PSLVERR}, 32'h0);
        check_output("rstwait XFER_COUNT", {16'b0, XFER_COUNT}, 32'h0);
        check_output("rstwait PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h0);
        idle_cycles(1);
        apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'd0, 1'b0, rdata, slverr, wait_seen, timed_out);
        check_output("rstwait mem", rdata, 32'hA5A5_1234);
        check_output("rstwait XFER after", {16'b0, XFER_COUNT}, 32'h1);
        idle_cycles(1);

        // Reset coinciding with the completion edge of a zero-wait write.
        start_transfer(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 4'd0);
        @(negedge PCLK);
        check_output("rstready PREADY before", {31'b0, PREADY}, 32'h1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check_output("rstready PREADY", {31'b0, PREADY}, 32'h0);
        check_output("rstready XFER_COUNT", {16'b0, XFER_COUNT}, 32'h0);
        idle_cycles(1);
        apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'd2, 1'b0, rdata, slverr, wait_seen, timed_out);
        check_output("rstready mem", rdata, 32'hA5A5_1234);
        check_output("rstready wait states", wait_seen, 32'd2);
        check_output("rstready XFER after", {16'b0, XFER_COUNT}, 32'h1);
        check_output("rstready PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h0);

        // Access phase presented in IDLE without a setup.
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        check_output("idle access PROTOCOL_ERR", {31'b0, PROTOCOL_ERR}, 32'h1);
        check_output("idle access PREADY", {31'b0, PREADY}, 32'h0);
        check_output("idle access XFER_COUNT", {16'b0, XFER_COUNT}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
